dnn2ami_mc: RTL and testbench

Parametrised memory-controller bridge between the DNN accelerator's PU read/write request interface and a single AMI-style memory request/response port. It generalises the single-PU and multi-PU bridges into one block. Features:
- Any `NUM_PU`.
- Burst splitting into `AXI_DATA_W` beats.
- Bounded outstanding reads.
- Round-robin read/write arbitration.
- Back-pressured response forwarding into the input buffer.

It sits between the accelerator's memory-controller FSM and the AMI memory port.

---
 rtl/dnn2ami_mc.sv | 198 +++++++++++++++++++
 tb/tb_dnn2ami_mc.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn2ami_mc.sv
// dnn2ami_mc: bridges the accelerator's PU read/write burst requests onto a
// single AMI-style memory port. Bursts are split into AXI_DATA_W beats, reads
// are limited by an outstanding-beat credit, and the two engines share the
// port through a two-way round-robin arbiter that holds its choice until the
// port grants it.
module dnn2ami_mc #(
  parameter int NUM_PU             = 2,
  parameter int AXI_DATA_W         = 64,
  parameter int ADDR_W             = 32,
  parameter int TX_SIZE_WIDTH      = 10,
  parameter int MAX_RD_OUTSTANDING = 8,
  parameter int PU_ID_W            = $clog2(NUM_PU) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rd_req,
  output logic                         rd_ready,
  input  logic [TX_SIZE_WIDTH-1:0]     rd_req_size,
  input  logic [ADDR_W-1:0]            rd_addr,
  input  logic                         wr_req,
  input  logic [PU_ID_W-1:0]           wr_pu_id,
  output logic                         wr_ready,
  input  logic [TX_SIZE_WIDTH-1:0]     wr_req_size,
  input  logic [ADDR_W-1:0]            wr_addr,
  output logic                         wr_done,
  input  logic [NUM_PU-1:0]            outbuf_empty,
  output logic [NUM_PU-1:0]            outbuf_pop,
  input  logic [NUM_PU*AXI_DATA_W-1:0] data_from_outbuf,
  input  logic                         inbuf_full,
  output logic                         inbuf_push,
  output logic [AXI_DATA_W-1:0]        data_to_inbuf,
  output logic                         mem_req_valid,
  input  logic                         mem_req_grant,
  output logic                         mem_req_write,
  output logic [ADDR_W-1:0]            mem_req_addr,
  output logic [AXI_DATA_W-1:0]        mem_req_data,
  input  logic                         mem_resp_valid,
  input  logic [AXI_DATA_W-1:0]        mem_resp_data,
  output logic                         mem_resp_grant
);

  localparam int OW = $clog2(MAX_RD_OUTSTANDING + 1);
  localparam logic [ADDR_W-1:0]        STEP = ADDR_W'(AXI_DATA_W / 8);
  localparam logic [OW-1:0]            OMAX = OW'(MAX_RD_OUTSTANDING);
  localparam logic [TX_SIZE_WIDTH-1:0] ONE  = TX_SIZE_WIDTH'(1);

  typedef enum logic       {R_IDLE, R_ISSUE} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_FETCH, W_ISSUE, W_DONE} wr_state_t;

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;

  logic [ADDR_W-1:0]        rd_addr_q, wr_addr_q;
  logic [TX_SIZE_WIDTH-1:0] rd_rem, wr_rem;
  logic [PU_ID_W-1:0]       wr_pu_q;
  logic [AXI_DATA_W-1:0]    wr_hold, pu_data;
  logic [OW-1:0]            rd_out;
  logic [NUM_PU-1:0]        pu_sel;
  logic rd_acc, wr_acc, rd_want, wr_want, rd_gnt, wr_gnt, resp_acc;
  logic fetch_rdy, pu_ok, sel_wr, last_wr, lock_q, lock_wr;

  assign rd_acc   = rd_req && rd_ready;
  assign wr_acc   = wr_req && wr_ready;
  assign pu_ok    = wr_pu_id < PU_ID_W'(NUM_PU);
  assign resp_acc = mem_resp_valid && !inbuf_full;

  // Response path is a pure pass-through gated only by input-buffer space.
  assign mem_resp_grant = resp_acc;
  assign inbuf_push     = resp_acc;
  assign data_to_inbuf  = mem_resp_data;

  // Decode the latched PU id and pick that PU's FWFT head word.
  always_comb begin
    pu_data = '0;
    for (int i = 0; i < NUM_PU; i++) begin
      pu_sel[i] = (wr_pu_q == PU_ID_W'(i));
      if (pu_sel[i]) pu_data = data_from_outbuf[i*AXI_DATA_W +: AXI_DATA_W];
    end
  end
  assign fetch_rdy = |(pu_sel & ~outbuf_empty);

  // Read engine state register.
  always_ff @(posedge clk) begin
    if (reset) rd_state <= R_IDLE;
    else       rd_state <= rd_next;
  end

  // Read engine next state: zero-length bursts never leave idle.
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (rd_acc && rd_req_size != '0) rd_next = R_ISSUE;
      R_ISSUE: if (rd_gnt && rd_rem == ONE)     rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // Read engine outputs: request only while credit remains.
  always_comb begin
    rd_ready = (rd_state == R_IDLE) && !reset;
    rd_want  = (rd_state == R_ISSUE) && (rd_out < OMAX);
  end

  // Write engine state register.
  always_ff @(posedge clk) begin
    if (reset) wr_state <= W_IDLE;
    else       wr_state <= wr_next;
  end

  // Write engine next state: empty or invalid-PU bursts report done at once.
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (wr_acc) wr_next = (wr_req_size == '0 || !pu_ok) ? W_DONE : W_FETCH;
      W_FETCH: if (fetch_rdy) wr_next = W_ISSUE;
      W_ISSUE: if (wr_gnt) wr_next = (wr_rem == ONE) ? W_DONE : W_FETCH;
      W_DONE:  wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // Write engine outputs: pop exactly in the cycle the head word is captured.
  always_comb begin
    wr_ready   = (wr_state == W_IDLE) && !reset;
    wr_done    = (wr_state == W_DONE) && !reset;
    wr_want    = (wr_state == W_ISSUE);
    outbuf_pop = (wr_state == W_FETCH && !reset) ? (pu_sel & ~outbuf_empty) : '0;
  end

  // Arbiter: a pending ungranted request keeps its winner; otherwise ties go
  // to the engine that lost the previous grant.
  always_comb begin
    if (lock_q)                sel_wr = lock_wr;
    else if (rd_want && wr_want) sel_wr = !last_wr;
    else                       sel_wr = wr_want;
    mem_req_valid = (rd_want || wr_want) && !reset;
    rd_gnt        = mem_req_valid && mem_req_grant && !sel_wr;
    wr_gnt        = mem_req_valid && mem_req_grant && sel_wr;
    mem_req_write = mem_req_valid && sel_wr;
    mem_req_addr  = !mem_req_valid ? '0 : (sel_wr ? wr_addr_q : rd_addr_q);
    mem_req_data  = (mem_req_valid && sel_wr) ? wr_hold : '0;
  end

  // Arbiter history: last winner and hold-until-grant lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_wr <= 1'b1;
      lock_q  <= 1'b0;
      lock_wr <= 1'b0;
    end else begin
      if (mem_req_valid && mem_req_grant) last_wr <= sel_wr;
      lock_q  <= mem_req_valid && !mem_req_grant;
      lock_wr <= sel_wr;
    end
  end

  // Outstanding read beats: +1 per read grant, -1 per accepted response.
  always_ff @(posedge clk) begin
    if (reset)                              rd_out <= '0;
    else if (rd_gnt && !resp_acc)           rd_out <= rd_out + OW'(1);
    else if (!rd_gnt && resp_acc && rd_out != '0) rd_out <= rd_out - OW'(1);
  end

  // Read datapath: beat address and remaining count.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_q <= '0;
      rd_rem    <= '0;
    end else if (rd_acc) begin
      rd_addr_q <= rd_addr;
      rd_rem    <= rd_req_size;
    end else if (rd_gnt) begin
      rd_addr_q <= rd_addr_q + STEP;
      rd_rem    <= rd_rem - ONE;
    end
  end

  // Write datapath: PU id, beat address, remaining count and holding word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_pu_q   <= '0;
      wr_addr_q <= '0;
      wr_rem    <= '0;
      wr_hold   <= '0;
    end else begin
      if (wr_acc) begin
        wr_pu_q   <= wr_pu_id;
        wr_addr_q <= wr_addr;
        wr_rem    <= wr_req_size;
      end else if (wr_gnt) begin
        wr_addr_q <= wr_addr_q + STEP;
        wr_rem    <= wr_rem - ONE;
      end
      if (wr_state == W_FETCH && fetch_rdy) wr_hold <= pu_data;
    end
  end

endmodule

// File: tb/tb_dnn2ami_mc.sv
// Directed bench for dnn2ami_mc (NUM_PU=2, 64-bit beats, 8 read credits).
// A memory/output-buffer environment answers reads two cycles after grant and
// a monitor logs port events per cycle; each test task checks those logs.
module tb_dnn2ami_mc;
  logic         clk = 0, reset = 1;
  logic         rd_req = 0, rd_ready;
  logic [9:0]   rd_req_size = 0;
  logic [31:0]  rd_addr = 0;
  logic         wr_req = 0, wr_ready, wr_done;
  logic [1:0]   wr_pu_id = 0;
  logic [9:0]   wr_req_size = 0;
  logic [31:0]  wr_addr = 0;
  logic [1:0]   outbuf_empty, outbuf_pop;
  logic [127:0] data_from_outbuf;
  logic         inbuf_full = 0, inbuf_push;
  logic [63:0]  data_to_inbuf;
  logic         mem_req_valid, mem_req_grant = 0, mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [63:0]  mem_req_data;
  logic         mem_resp_valid, mem_resp_grant;
  logic [63:0]  mem_resp_data;

  dnn2ami_mc dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_req_size(rd_req_size), .rd_addr(rd_addr),
    .wr_req(wr_req), .wr_pu_id(wr_pu_id), .wr_ready(wr_ready), .wr_req_size(wr_req_size),
    .wr_addr(wr_addr), .wr_done(wr_done),
    .outbuf_empty(outbuf_empty), .outbuf_pop(outbuf_pop), .data_from_outbuf(data_from_outbuf),
    .inbuf_full(inbuf_full), .inbuf_push(inbuf_push), .data_to_inbuf(data_to_inbuf),
    .mem_req_valid(mem_req_valid), .mem_req_grant(mem_req_grant), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_grant(mem_resp_grant)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  typedef struct { bit wr; logic [31:0] addr; logic [63:0] data; int cyc; } gnt_t;
  gnt_t        gq[$];
  logic [63:0] pq[$];
  int          pc0[$], pc1[$], dq[$];
  int          racc = 0, wacc = 0;

  logic [63:0] rq[$];
  int          rdue[$];
  logic [63:0] ob0[$], ob1[$];
  bit          resp_en = 0;
  int          inj_req = 0, inj_done = 0;

  // Environment: read responses, injected responses, FWFT output buffers.
  initial begin
    logic acc, rg;
    logic [31:0] ra;
    logic [1:0] pops;
    logic [63:0] tmp;
    mem_resp_valid = 0; mem_resp_data = 0; outbuf_empty = 2'b11; data_from_outbuf = 0;
    forever begin
      @(negedge clk);
      acc  = mem_resp_valid && !inbuf_full;
      rg   = mem_req_valid && mem_req_grant && !mem_req_write;
      ra   = mem_req_addr;
      pops = outbuf_pop;
      @(posedge clk); #1;
      if (acc && rq.size() > 0) begin tmp = rq.pop_front(); rdue.pop_front(); end
      if (rg && resp_en) begin rq.push_back({32'hD0D0_0000, ra}); rdue.push_back(cyc + 1); end
      if (inj_req != inj_done) begin
        rq.push_back(64'hD0D0_0000_0000_1EC7); rdue.push_back(cyc); inj_done++;
      end
      if (pops[0] && ob0.size() > 0) tmp = ob0.pop_front();
      if (pops[1] && ob1.size() > 0) tmp = ob1.pop_front();
      mem_resp_valid = (rq.size() > 0) && (rdue[0] <= cyc);
      mem_resp_data  = (rq.size() > 0) ? rq[0] : 64'h0;
      outbuf_empty[0] = (ob0.size() == 0);
      outbuf_empty[1] = (ob1.size() == 0);
      data_from_outbuf[63:0]   = (ob0.size() > 0) ? ob0[0] : 64'h0;
      data_from_outbuf[127:64] = (ob1.size() > 0) ? ob1[0] : 64'h0;
    end
  end

  // Monitor: log every handshake seen mid-cycle.
  initial begin
    gnt_t g;
    forever begin
      @(negedge clk);
      if (mem_req_valid && mem_req_grant) begin
        g.wr = mem_req_write; g.addr = mem_req_addr; g.data = mem_req_data; g.cyc = cyc;
        gq.push_back(g);
      end
      if (inbuf_push)    pq.push_back(data_to_inbuf);
      if (outbuf_pop[0]) pc0.push_back(cyc);
      if (outbuf_pop[1]) pc1.push_back(cyc);
      if (wr_done)       dq.push_back(cyc);
      if (rd_req && rd_ready) racc = cyc;
      if (wr_req && wr_ready) wacc = cyc;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step; @(posedge clk); #1; endtask

  task automatic clear_logs;
    gq.delete(); pq.delete(); pc0.delete(); pc1.delete(); dq.delete();
  endtask

  task automatic issue_rd(input logic [31:0] a, input int n);
    rd_req = 1; rd_addr = a; rd_req_size = 10'(n); step; rd_req = 0;
  endtask

  task automatic issue_wr(input int pu, input logic [31:0] a, input int n);
    wr_req = 1; wr_pu_id = 2'(pu); wr_addr = a; wr_req_size = 10'(n); step; wr_req = 0;
  endtask

  task automatic test_reset;
    reset = 1; step; step;
    @(negedge clk);
    total++;
    if ({rd_ready, wr_ready, mem_req_valid, outbuf_pop, wr_done, inbuf_push, mem_req_write} !== 8'h0) begin
      bad++; $display("FAIL reset_outs: got %b want 0",
        {rd_ready, wr_ready, mem_req_valid, outbuf_pop, wr_done, inbuf_push, mem_req_write});
    end
    total++;
    if (mem_req_addr !== 32'h0 || mem_req_data !== 64'h0) begin
      bad++; $display("FAIL reset_fields: got %h/%h want 0", mem_req_addr, mem_req_data);
    end
    step; reset = 0; step;
    @(negedge clk);
    total++;
    if ({rd_ready, wr_ready} !== 2'b11) begin
      bad++; $display("FAIL ready_after_reset: got %b want 11", {rd_ready, wr_ready});
    end
  endtask

  task automatic test_read_burst;
    step; clear_logs(); resp_en = 1; mem_req_grant = 1; step;
    issue_rd(32'h100, 4);
    for (int k = 0; k < 40 && pq.size() < 4; k++) @(negedge clk);
    total++;
    if (gq.size() != 4) begin bad++; $display("FAIL rd_gnt_count: got %0d want 4", gq.size()); end
    for (int i = 0; i < gq.size(); i++) begin
      total++;
      if (gq[i].wr !== 1'b0 || gq[i].addr !== 32'h100 + 32'(8*i) || gq[i].cyc != racc + 1 + i) begin
        bad++; $display("FAIL rd_beat[%0d]: got w=%0d a=%h c=%0d want w=0 a=%h c=%0d",
          i, gq[i].wr, gq[i].addr, gq[i].cyc, 32'h100 + 32'(8*i), racc + 1 + i);
      end
    end
    total++;
    if (pq.size() != 4) begin bad++; $display("FAIL rd_push_count: got %0d want 4", pq.size()); end
    for (int i = 0; i < pq.size(); i++) begin
      total++;
      if (pq[i] !== {32'hD0D0_0000, 32'h100 + 32'(8*i)}) begin
        bad++; $display("FAIL rd_push[%0d]: got %h want %h", i, pq[i], {32'hD0D0_0000, 32'h100 + 32'(8*i)});
      end
    end
  endtask

  task automatic test_write;
    logic [63:0] exp_d [3];
    exp_d[0] = 64'hA; exp_d[1] = 64'hB; exp_d[2] = 64'hC;
    step; clear_logs(); mem_req_grant = 1;
    ob1.push_back(64'hA); ob1.push_back(64'hB); ob1.push_back(64'hC);
    step;
    issue_wr(1, 32'h40, 3);
    for (int k = 0; k < 40 && dq.size() < 1; k++) @(negedge clk);
    step; step;
    total++;
    if (gq.size() != 3) begin bad++; $display("FAIL wr_gnt_count: got %0d want 3", gq.size()); end
    for (int i = 0; i < gq.size(); i++) begin
      total++;
      if (gq[i].wr !== 1'b1 || gq[i].addr !== 32'h40 + 32'(8*i) || gq[i].data !== exp_d[i] ||
          gq[i].cyc != wacc + 2 + 2*i) begin
        bad++; $display("FAIL wr_beat[%0d]: got w=%0d a=%h d=%h c=%0d want w=1 a=%h d=%h c=%0d",
          i, gq[i].wr, gq[i].addr, gq[i].data, gq[i].cyc, 32'h40 + 32'(8*i), exp_d[i], wacc + 2 + 2*i);
      end
    end
    total++;
    if (pc1.size() != 3 || pc0.size() != 0) begin
      bad++; $display("FAIL wr_pop_count: got pu1=%0d pu0=%0d want 3/0", pc1.size(), pc0.size());
    end
    for (int i = 0; i < pc1.size(); i++) begin
      total++;
      if (pc1[i] != wacc + 1 + 2*i) begin
        bad++; $display("FAIL wr_pop_cyc[%0d]: got %0d want %0d", i, pc1[i], wacc + 1 + 2*i);
      end
    end
    total++;
    if (dq.size() != 1 || dq[0] != wacc + 7) begin
      bad++; $display("FAIL wr_done: got n=%0d c=%0d want n=1 c=%0d", dq.size(),
        (dq.size() > 0) ? dq[0] : -1, wacc + 7);
    end
  endtask

  task automatic test_hold_backpressure;
    step; clear_logs(); mem_req_grant = 0; resp_en = 1;
    ob1.push_back(64'h1234);
    step;
    issue_wr(1, 32'h80, 1);
    for (int k = 0; k < 10 && !mem_req_valid; k++) @(negedge clk);
    step;
    issue_rd(32'h500, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b1 || mem_req_addr !== 32'h80 ||
          mem_req_data !== 64'h1234) begin
        bad++; $display("FAIL hold[%0d]: got v=%0d w=%0d a=%h d=%h want 1/1/80/1234",
          i, mem_req_valid, mem_req_write, mem_req_addr, mem_req_data);
      end
    end
    step; inbuf_full = 1; mem_req_grant = 1;
    for (int k = 0; k < 10 && gq.size() < 2; k++) @(negedge clk);
    total++;
    if (gq.size() != 2 || gq[0].wr !== 1'b1 || gq[0].addr !== 32'h80 || gq[1].wr !== 1'b0 ||
        gq[1].addr !== 32'h500) begin
      bad++; $display("FAIL hold_order: got n=%0d want write 80 then read 500", gq.size());
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (mem_resp_grant !== 1'b0 || inbuf_push !== 1'b0) begin
        bad++; $display("FAIL resp_stall[%0d]: got g=%0d p=%0d want 0/0", i, mem_resp_grant, inbuf_push);
      end
    end
    step; inbuf_full = 0;
    for (int k = 0; k < 10 && pq.size() < 1; k++) @(negedge clk);
    total++;
    if (pq.size() != 1 || pq[0] !== 64'hD0D0_0000_0000_0500) begin
      bad++; $display("FAIL resp_release: got n=%0d d=%h want 1 d00d...0500", pq.size(),
        (pq.size() > 0) ? pq[0] : 64'h0);
    end
  endtask

  task automatic test_arbitration;
    reset = 1; step; reset = 0; clear_logs(); mem_req_grant = 1; resp_en = 1;
    for (int i = 0; i < 4; i++) ob0.push_back(64'h1000 + 64'(i));
    step;
    wr_req = 1; wr_pu_id = 0; wr_addr = 32'h300; wr_req_size = 4; step; wr_req = 0;
    issue_rd(32'h200, 4);
    for (int k = 0; k < 40 && (gq.size() < 8 || pq.size() < 4 || dq.size() < 1); k++) @(negedge clk);
    total++;
    if (gq.size() != 8) begin bad++; $display("FAIL arb_count: got %0d want 8", gq.size()); end
    for (int i = 0; i < gq.size(); i++) begin
      logic [31:0] ea;
      ea = (i % 2 == 0) ? 32'h200 + 32'(8*(i/2)) : 32'h300 + 32'(8*(i/2));
      total++;
      if (gq[i].wr !== 1'(i % 2) || gq[i].addr !== ea || gq[i].cyc != wacc + 2 + i ||
          (i % 2 == 1 && gq[i].data !== 64'h1000 + 64'(i/2))) begin
        bad++; $display("FAIL arb[%0d]: got w=%0d a=%h c=%0d want w=%0d a=%h c=%0d",
          i, gq[i].wr, gq[i].addr, gq[i].cyc, i % 2, ea, wacc + 2 + i);
      end
    end
  endtask

  task automatic test_boundaries;
    step; clear_logs(); mem_req_grant = 1; resp_en = 1;
    issue_wr(2, 32'h600, 5);
    repeat (4) @(negedge clk);
    total++;
    if (dq.size() != 1 || dq[0] != wacc + 1 || gq.size() != 0 || pc0.size() + pc1.size() != 0) begin
      bad++; $display("FAIL bad_pu: got done_n=%0d gnt=%0d pops=%0d want 1/0/0", dq.size(),
        gq.size(), pc0.size() + pc1.size());
    end
    step; clear_logs();
    issue_wr(0, 32'h680, 0);
    repeat (4) @(negedge clk);
    total++;
    if (dq.size() != 1 || dq[0] != wacc + 1 || gq.size() != 0) begin
      bad++; $display("FAIL wr_size0: got done_n=%0d gnt=%0d want 1/0", dq.size(), gq.size());
    end
    step; clear_logs();
    issue_rd(32'h700, 0);
    repeat (4) @(negedge clk);
    total++;
    if (gq.size() != 0 || rd_ready !== 1'b1) begin
      bad++; $display("FAIL rd_size0: got gnt=%0d ready=%0d want 0/1", gq.size(), rd_ready);
    end
    step; clear_logs();
    issue_rd(32'hFFFF_FFF8, 2);
    for (int k = 0; k < 20 && pq.size() < 2; k++) @(negedge clk);
    total++;
    if (gq.size() != 2 || gq[0].addr !== 32'hFFFF_FFF8 || gq[1].addr !== 32'h0) begin
      bad++; $display("FAIL addr_wrap: got n=%0d a1=%h want 2 beats fffffff8,00000000", gq.size(),
        (gq.size() > 1) ? gq[1].addr : 32'hx);
    end
  endtask

  task automatic test_credit_reset;
    step; clear_logs(); mem_req_grant = 1; resp_en = 0;
    issue_rd(32'h1000, 10);
    repeat (20) @(negedge clk);
    total++;
    if (gq.size() != 8 || mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL credit_stall: got gnt=%0d v=%0d want 8/0", gq.size(), mem_req_valid);
    end
    step; inj_req++;
    repeat (8) @(negedge clk);
    total++;
    if (gq.size() != 9 || pq.size() != 1 || mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL credit_one: got gnt=%0d push=%0d v=%0d want 9/1/0", gq.size(), pq.size(), mem_req_valid);
    end
    step; mem_req_grant = 0; inj_req++;
    repeat (6) @(negedge clk);
    total++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1048) begin
      bad++; $display("FAIL credit_pending: got v=%0d a=%h want 1/1048", mem_req_valid, mem_req_addr);
    end
    step; reset = 1; step;
    @(negedge clk);
    total++;
    if ({rd_ready, wr_ready, mem_req_valid, outbuf_pop, wr_done, inbuf_push, mem_req_write} !== 8'h0 ||
        mem_req_addr !== 32'h0) begin
      bad++; $display("FAIL midread_reset: got %b a=%h want 0",
        {rd_ready, wr_ready, mem_req_valid, outbuf_pop, wr_done, inbuf_push, mem_req_write}, mem_req_addr);
    end
    step; reset = 0; mem_req_grant = 1; clear_logs(); step;
    issue_rd(32'h2000, 10);
    repeat (20) @(negedge clk);
    total++;
    if (gq.size() != 8 || gq[0].addr !== 32'h2000) begin
      bad++; $display("FAIL credit_after_reset: got gnt=%0d want 8 from 2000", gq.size());
    end
    reset = 1; step; step; reset = 0; step;
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_write();
    test_hold_backpressure();
    test_arbitration();
    test_boundaries();
    test_credit_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
